// File: rtl/nibble_router_arbiter_pkg.sv
// Shared types and constants for the nibble router arbiter: FSM state,
// path widths and the nibble slice helper.
package router_pkg;
  localparam int NUM_REQ  = 4;
  localparam int NIBBLE_W = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {IDLE, BUSY} state_t;

  // Low bit of nibble i in a packed nibble vector.
  function automatic int nib_lo(input logic [SEL_W-1:0] i);
    return int'(i) * NIBBLE_W;
  endfunction
endpackage

// File: rtl/nibble_router_arbiter_rr_picker.sv
// Combinational rotating-priority search: first set req bit starting at
// (last+1) mod 4 and wrapping upward.
module rr_picker
  import router_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/nibble_router_arbiter.sv
// Round-robin slot arbiter for the 4:1 nibble mux / 1:4 demux path; commits
// the routed nibble into a registered destination bank at slot end.
module nibble_router_arbiter #(
  parameter int SLOT_CYCLES = 4,
  parameter int NUM_REQ     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*4-1:0]  src_data,
  input  logic [NUM_REQ*2-1:0]  dest,
  output logic [1:0]            src_sel,
  output logic [1:0]            dst_sel,
  output logic                  bus_en,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  done,
  output logic [NUM_REQ*4-1:0]  dest_bank
);
  import router_pkg::*;

  localparam logic [3:0] CNT_LAST = 4'(SLOT_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] last;
  logic             found;
  logic [SEL_W-1:0] pick_idx;

  rr_picker u_pick (
    .req   (req),
    .last  (last),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      src_sel   <= '0;
      dst_sel   <= '0;
      bus_en    <= 1'b0;
      done      <= 1'b0;
      dest_bank <= '0;
      cnt       <= '0;
      last      <= 2'd3;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= NUM_REQ'(1) << pick_idx;
            src_sel <= pick_idx;
            // destination is latched here; later dest changes are ignored
            dst_sel <= dest[int'(pick_idx)*SEL_W +: SEL_W];
            bus_en  <= 1'b1;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            dest_bank[nib_lo(dst_sel) +: NIBBLE_W] <= src_data[nib_lo(src_sel) +: NIBBLE_W];
            done   <= 1'b1;
            grant  <= '0;
            bus_en <= 1'b0;
            last   <= src_sel;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_router_arbiter.sv
// Bench for nibble_router_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_nibble_router_arbiter;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] src_data = '0;
  logic [7:0]  dest = '0;
  logic [1:0]  src_sel, dst_sel;
  logic        bus_en, done;
  logic [3:0]  grant;
  logic [15:0] dest_bank;

  int errors = 0;
  int checks = 0;

  nibble_router_arbiter #(.SLOT_CYCLES(S), .NUM_REQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .src_data(src_data), .dest(dest),
    .src_sel(src_sel), .dst_sel(dst_sel), .bus_en(bus_en), .grant(grant),
    .done(done), .dest_bank(dest_bank)
  );

  always #5 clk = ~clk;

  // Reference model: a slot is "cycles left on the bus"; commit when it runs out.
  int         left;
  int         m_src, m_dst, m_last;
  logic [3:0] bank [4];
  logic       m_done;
  logic       mvalid = 1'b0;

  always @(posedge clk) begin
    mvalid = 1'b1;
    if (reset) begin
      left = 0; m_src = 0; m_dst = 0; m_last = 3; m_done = 0;
      for (int d = 0; d < 4; d++) bank[d] = 4'h0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          bank[m_dst] = src_data[m_src*4 +: 4];
          m_done = 1;
          m_last = m_src;
        end
      end else if (req != 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (left == 0 && req[(m_last + k) % 4]) begin
            m_src = (m_last + k) % 4;
            m_dst = dest[m_src*2 +: 2];
            left  = S;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [15:0] eb;
      logic [3:0]  eg;
      eb = {bank[3], bank[2], bank[1], bank[0]};
      eg = (left > 0) ? (4'b0001 << m_src) : 4'b0000;
      checks++;
      if (grant !== eg || bus_en !== (left > 0) || done !== m_done ||
          src_sel !== 2'(m_src) || dst_sel !== 2'(m_dst) || dest_bank !== eb) begin
        errors++;
        $display("FAIL model t=%0t got g=%b en=%b dn=%b ss=%0d ds=%0d bank=%h want g=%b en=%b dn=%b ss=%0d ds=%0d bank=%h",
                 $time, grant, bus_en, done, src_sel, dst_sel, dest_bank,
                 eg, left > 0, m_done, m_src, m_dst, eb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_new_grant(output logic [3:0] g);
    logic seen;
    seen = (grant == 4'b0);
    g = 4'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (grant == 4'b0) seen = 1'b1;
      else if (seen) begin
        g = grant;
        return;
      end
    end
    chk("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] prev;
    int ens, dns, ng;
    logic [3:0] seq [5];

    // reset with all requesters active
    req = 4'hF;
    step(2);
    chk("rst_grant", grant, 4'h0);
    chk("rst_bus_en", bus_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bank", dest_bank, 16'h0000);
    chk("rst_sel", {src_sel, dst_sel}, 4'h0);
    reset = 1'b0;
    step(1);
    chk("first_grant", grant, 4'b0001);
    do_reset(1);

    // single transfer req0 -> dest 2
    req = 4'b0001; dest = 8'h02; src_data = 16'h000A;
    step(1);
    chk("single_grant", grant, 4'b0001);
    chk("single_src", src_sel, 2'd0);
    chk("single_dst", dst_sel, 2'd2);
    req = 4'b0000;
    ens = 1; dns = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      ens += int'(bus_en);
      dns += int'(done);
    end
    chk("single_en_cycles", ens, 4);
    chk("single_done_pulses", dns, 1);
    chk("single_bank", dest_bank, 16'h0A00);

    // full contention
    do_reset(1);
    req = 4'hF; dest = 8'h1B; src_data = 16'h4321;
    prev = 4'b0; ng = 0;
    for (int i = 0; i < 22; i++) begin
      step(1);
      if (grant != 4'b0 && prev == 4'b0 && ng < 5) begin
        seq[ng] = grant;
        ng++;
      end
      prev = grant;
    end
    req = 4'b0;
    step(6);
    chk("cont_count", ng, 5);
    chk("cont_seq", {seq[0], seq[1], seq[2], seq[3], seq[4]}, 20'h12481);
    chk("cont_bank", dest_bank, 16'h1234);

    // wrap-around: serve 2, then 0101 must go 0 then 2
    req = 4'b0100;
    wait_new_grant(g);
    chk("wrap_g2", g, 4'b0100);
    req = 4'b0101;
    wait_new_grant(g);
    chk("wrap_g0", g, 4'b0001);
    wait_new_grant(g);
    chk("wrap_g2b", g, 4'b0100);
    req = 4'b0;

    // mid-slot req drop and dest change
    dest = 8'h0C; src_data = 16'h0050; req = 4'b0010;
    wait_new_grant(g);
    chk("mid_grant", g, 4'b0010);
    chk("mid_dst", dst_sel, 2'd3);
    step(1);
    req = 4'b0; dest = 8'h00;
    dns = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      dns += int'(done);
    end
    chk("mid_done", dns, 1);
    chk("mid_bank_n3", dest_bank[15:12], 4'h5);

    // reset in the middle of a slot
    do_reset(2);
    req = 4'b0001; dest = 8'h01; src_data = 16'h000F;
    step(1);
    chk("rmid_grant", grant, 4'b0001);
    req = 4'b0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req = 4'b1010;
    dns = 0;
    for (int i = 0; i < 3; i++) begin
      dns += int'(done);
      if (grant != 4'b0) break;
      step(1);
    end
    chk("rmid_no_done", dns, 0);
    chk("rmid_bank", dest_bank, 16'h0000);
    chk("rmid_next_grant", grant, 4'b0010);
    req = 4'b0;
    step(8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      req      = ($urandom_range(3) == 0) ? 4'b0 : 4'($urandom);
      dest     = 8'($urandom);
      src_data = 16'($urandom);
      reset    = ($urandom_range(255) == 0);
      step(1);
    end
    reset = 1'b0; req = 4'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
